// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV64I+Zba pipeline: execute-stage
// forwarding, load-use and branch stall/flush, multi-cycle op sequencing
// with a timeout watchdog, and a saturating stall-cycle counter.
//
// state | meaning
// IDLE  | no multi-cycle op in flight; MDStart issued when one reaches E
// BUSY  | multi-cycle unit working; pipeline held until MDDone or abort
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [4:0]       Rd_M,
  input  logic [4:0]       Rd_W,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             LoadOp_E,
  input  logic             PCSrc_E,
  input  logic             MulDiv_E,
  input  logic             MDDone,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Flush_M,
  output logic             MDStart,
  output logic             MDAbort,
  output logic             MDTimeout,
  output logic [CNT_W-1:0] StallCount
);

  localparam int BCW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [BCW-1:0] CNT_LAST = BCW'(MD_TIMEOUT - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]     state;
  logic [BCW-1:0] busy_cnt;
  logic           lw_stall;
  logic           md_stall;
  logic           abort;

  // Forwarding selects; memory stage beats writeback, x0 never forwards.
  always_comb begin
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b00;
    if (!rst) begin
      if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == Rs1_E))
        ForwardA_E = 2'b10;
      else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs1_E))
        ForwardA_E = 2'b01;
      if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == Rs2_E))
        ForwardB_E = 2'b10;
      else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs2_E))
        ForwardB_E = 2'b01;
    end
  end

  // Stall/flush decode; every control output is forced low while reset is held.
  always_comb begin
    lw_stall = LoadOp_E && (Rd_E != 5'd0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
    abort    = (state == BUSY) && !MDDone && (busy_cnt == CNT_LAST);
    md_stall = ((state == IDLE) && MulDiv_E) ||
               ((state == BUSY) && !MDDone && !abort);
    Stall_F  = !rst && (lw_stall || md_stall);
    Stall_D  = Stall_F;
    Stall_E  = !rst && md_stall;
    Flush_M  = !rst && md_stall;
    Flush_D  = !rst && PCSrc_E;
    // Execute holds the multi-cycle op, so it is never bubbled underneath it.
    Flush_E  = !rst && (lw_stall || PCSrc_E) && !md_stall;
    MDStart  = !rst && (state == IDLE) && MulDiv_E;
    MDAbort  = !rst && abort;
  end

  // Multi-cycle sequencing, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy_cnt  <= '0;
      MDTimeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy_cnt <= '0;
          if (MulDiv_E) state <= BUSY;
        end
        default: begin
          if (MDDone || abort) begin
            state    <= IDLE;
            busy_cnt <= '0;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
      endcase
      if (abort) MDTimeout <= 1'b1;
    end
  end

  // Performance counter of fetch-stall cycles, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      StallCount <= '0;
    else if (Stall_F && (StallCount != {CNT_W{1'b1}}))
      StallCount <= StallCount + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a table of single-cycle hazard
// vectors plus hand-written multi-cycle sequences, all routed through an
// expected-value queue that is popped at each falling edge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic        RegWrite_M, RegWrite_W, LoadOp_E, PCSrc_E, MulDiv_E, MDDone;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M;
  logic        MDStart, MDAbort, MDTimeout;
  logic [31:0] StallCount;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_ctrl #(.MD_TIMEOUT(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .LoadOp_E(LoadOp_E), .PCSrc_E(PCSrc_E), .MulDiv_E(MulDiv_E), .MDDone(MDDone),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M),
    .MDStart(MDStart), .MDAbort(MDAbort), .MDTimeout(MDTimeout),
    .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  // {fa, fb, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, start, abort, timeout}
  function automatic logic [12:0] mk(logic [1:0] fa, logic [1:0] fb, logic stl,
                                     logic se, logic fd, logic fe, logic fm,
                                     logic ms, logic ma, logic mt);
    return {fa, fb, stl, stl, se, fd, fe, fm, ms, ma, mt};
  endfunction

  typedef struct {
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        rw_m, rw_w, load, pcsrc;
    logic [12:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [12:0] exp;
  } sb_t;

  vec_t vecs[11];
  sb_t  sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Push the expectation for the cycle just driven, compare it at the falling
  // edge, then move to just after the next rising edge.
  task automatic step(input string name, input logic [12:0] e);
    sb_t s;
    sbq.push_back('{name, e});
    @(negedge clk);
    s = sbq.pop_front();
    chk(s.name, {19'd0, ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E,
                 Flush_D, Flush_E, Flush_M, MDStart, MDAbort, MDTimeout}, {19'd0, s.exp});
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; Rd_E = 0; Rd_M = 0; Rd_W = 0;
    RegWrite_M = 0; RegWrite_W = 0; LoadOp_E = 0; PCSrc_E = 0;
    MulDiv_E = 0; MDDone = 0;
  endtask

  // Mid-cycle reset with hazard-provoking inputs; outputs must collapse at once.
  task automatic do_reset(input string name);
    Rs1_E = 5; Rd_M = 5; RegWrite_M = 1; LoadOp_E = 1; Rd_E = 7; Rs1_D = 7;
    PCSrc_E = 1; MulDiv_E = 1;
    #1 rst = 1'b1;
    #1;
    chk({name, "_outs"}, {19'd0, ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E,
                          Flush_D, Flush_E, Flush_M, MDStart, MDAbort, MDTimeout}, 32'd0);
    chk({name, "_cnt"}, StallCount, 32'd0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [12:0] z, stl_md;

  initial begin
    z      = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    stl_md = mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 0);

    //          rs1_d rs2_d rs1_e rs2_e rd_e rd_m rd_w rw_m rw_w load pc
    vecs[0]  = '{0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{0, 0, 5, 0, 0, 5, 5, 0, 1, 0, 0, mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[2]  = '{0, 0, 5, 0, 0, 0, 0, 1, 1, 0, 0, z};
    vecs[3]  = '{0, 0, 3, 9, 0, 3, 9, 1, 1, 0, 0, mk(2'b10, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[4]  = '{0, 0, 12, 12, 0, 12, 12, 0, 0, 0, 0, z};
    vecs[5]  = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, mk(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0)};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, z};
    vecs[7]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 0, mk(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0)};
    vecs[8]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, z};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0)};
    vecs[10] = '{0, 4, 0, 0, 4, 0, 0, 0, 0, 1, 1, mk(2'b00, 2'b00, 1, 0, 1, 1, 0, 0, 0, 0)};

    clear_inputs();
    Rs1_E = 5; Rd_M = 5; RegWrite_M = 1; MulDiv_E = 1; PCSrc_E = 1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("por_outs", {19'd0, ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E,
                     Flush_D, Flush_E, Flush_M, MDStart, MDAbort, MDTimeout}, 32'd0);
    chk("por_cnt", StallCount, 32'd0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      Rs1_D = vecs[i].rs1_d; Rs2_D = vecs[i].rs2_d;
      Rs1_E = vecs[i].rs1_e; Rs2_E = vecs[i].rs2_e;
      Rd_E = vecs[i].rd_e; Rd_M = vecs[i].rd_m; Rd_W = vecs[i].rd_w;
      RegWrite_M = vecs[i].rw_m; RegWrite_W = vecs[i].rw_w;
      LoadOp_E = vecs[i].load; PCSrc_E = vecs[i].pcsrc;
      step($sformatf("vec%0d", i), vecs[i].exp);
    end
    clear_inputs();
    step("idle_after_vecs", z);
    chk("stallcount_vecs", StallCount, 32'd3);

    do_reset("rst_a");

    // Multi-cycle op completing: start cycle, four held cycles, then MDDone.
    MulDiv_E = 1;
    step("md_start", mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 1, 0, 0));
    step("md_busy0", stl_md);
    LoadOp_E = 1; Rd_E = 7; Rs1_D = 7;
    step("md_busy1_lw", stl_md);
    LoadOp_E = 0; Rd_E = 0; Rs1_D = 0;
    step("md_busy2", stl_md);
    step("md_busy3", stl_md);
    MDDone = 1;
    step("md_done", z);
    chk("stallcount_md", StallCount, 32'd5);
    MulDiv_E = 0; MDDone = 1;
    step("md_done_idle_ignored", z);
    MDDone = 0;
    step("md_after", z);

    // Multi-cycle op that never completes.
    MulDiv_E = 1;
    step("to_start", mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < 63; i++) step($sformatf("to_busy%0d", i), stl_md);
    step("to_abort", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0));
    MulDiv_E = 0;
    step("to_sticky1", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
    step("to_sticky2", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));

    // Reset during BUSY cycle 3, then a fresh start.
    MulDiv_E = 1;
    step("rb_start", mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 1, 0, 1));
    for (int i = 0; i < 3; i++)
      step($sformatf("rb_busy%0d", i), mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 1));
    do_reset("rst_busy");
    MulDiv_E = 1;
    step("rb_restart", mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 1, 0, 0));
    step("rb_rebusy", stl_md);
    MDDone = 1;
    step("rb_done", z);
    MulDiv_E = 0; MDDone = 0;
    step("rb_idle", z);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
